syncer_bus_filt: RTL and testbench
==================================

Name: syncer_bus_filt

Overview:
Multi-channel, single-clock bus synchronizer with a stability qualifier. It samples asynchronous or quasi-static buses (config words, status from other domains, GPIO) into clk through a SYNC_STAGES flop chain. A channel's output is updated only after its value has been stable for STABLE_CNT consecutive cycles, so multi-bit skew and glitches never reach the output. It generalises the request/acknowledge bus transfer to NUM_CH channels, adds configurable depth and qualification, and adds per-channel update strobes.

Parameters:
- WIDTH, 8, bits per channel.
- NUM_CH, 1, number of independent channels.
- SYNC_STAGES, 2, flop stages in the metastability chain; legal range is 2 or more.
- STABLE_CNT, 4, consecutive equal synchronized samples required to qualify; legal range is 1 or more.
- GLITCH_W, 8, glitch counter width. Used only with the optional feature.

Ports:
- clk, input, 1, sole clock.
- reset, input, 1, asynchronous, active-high reset.
- busin, input, NUM_CH*WIDTH, asynchronous inputs; channel ch occupies [ch*WIDTH +: WIDTH].
- busout, output, NUM_CH*WIDTH, qualified outputs; same channel packing as busin.
- ready, output, NUM_CH, level; channel has qualified at least once since reset.
- upd, output, NUM_CH, one-cycle pulse when busout[ch] is loaded.
- glitch_clr, input, 1, synchronous clear of all glitch counters. Present only with the optional feature.
- glitch_cnt, output, NUM_CH*GLITCH_W, per-channel glitch count. Present only with the optional feature.

Behaviour:
- Reset (asynchronous, effective immediately): sync chain, cand, cnt, prime counter, busout, ready, upd and glitch_cnt all clear to 0.
- Per channel, each edge: sync[0] <= busin[ch]; sync[k] <= sync[k-1]; s = sync[SYNC_STAGES-1].
- Priming: a shared counter forces the "mismatch" path for edges 1..SYNC_STAGES+1 after reset release, then saturates. Stale reset zeros in the chain therefore never qualify.
- Mismatch path (s != cand, or priming): cand <= s; cnt <= 0.
- Match, cnt < STABLE_CNT-1: cnt <= cnt+1.
- Match, cnt == STABLE_CNT-1 (qualified):
  - cnt holds.
  - If !ready or cand != busout: busout <= cand, upd pulses for 1 cycle, ready <= 1.
  - Otherwise no change and no upd.
- Counter width: cnt is max(1, clog2(STABLE_CNT)) bits and never wraps.
- Latency for a held step on busin: busout changes at edge SYNC_STAGES+STABLE_CNT+1 counted from the edge that first samples the new value (7 with defaults). The first qualification after reset has the same latency, counted from reset release.
- Input that changes again before qualifying restarts qualification. busout holds its last qualified value throughout.
- Once ready is set it stays 1 until reset.
- Channels are fully independent; simultaneous changes on several channels each follow their own timing.

Optional Feature:
- Macro: SYNCER_BUS_GLITCH_CNT_EN.
- Defined:
  - A glitch is a mismatch-path event (not priming) while ready=1 and cand != busout, i.e. a pending value abandoned before qualifying.
  - glitch_cnt[ch] increments by 1 per glitch and saturates at 2^GLITCH_W-1.
  - glitch_clr zeroes all counters on the next edge and takes priority over a same-cycle increment.
- Undefined: glitch_clr and glitch_cnt ports are absent and no counter logic is generated.

Decomposition:
- Package syncer_pkg holds:
  - function cnt_width(STABLE_CNT);
  - function prime_width(SYNC_STAGES);
  - localparam-style defaults shared with the other syncers.
- Sub-module syncer_bus_filt_ch implements one channel: chain, cand, cnt, busout, ready, upd, and glitch counter under the macro.
- Top level holds the shared prime counter and a generate loop over NUM_CH.

Test Plan:
1. Defaults; release reset with busin=0xA5 held. Required: busout=0x00 and ready=0 through edge 6; at edge 7 busout=0xA5, ready=1, upd=1 for exactly one cycle.
2. After scenario 1, step busin 0xA5->0x3C and hold. Required: busout=0x3C exactly 7 edges after the sampling edge, a single upd pulse, no intermediate values.
3. Set busin to 0xFF for 3 cycles, then back to 0x3C. Required: busout stays 0x3C, no upd; with macro, glitch_cnt=1. Then pulse glitch_clr. Required: glitch_cnt=0.
4. NUM_CH=4; toggle channel 2 only, 0x11->0x22. Required: only upd[2] pulses; busout on channels 0, 1 and 3 unchanged.
5. Assert reset mid-qualification (cnt=2 on a pending change). Required: busout, ready, upd and glitch_cnt go to 0 without a clock edge; after release the channel requalifies with scenario 1 timing.
6. SYNC_STAGES=3, STABLE_CNT=1, GLITCH_W=4. Required: step latency = 5 edges. Then generate 20 glitches. Required: glitch_cnt saturates at 15.

Source files
------------

// File: rtl/syncer_pkg.sv
// Shared defaults and width helpers for the syncer family.
// Optional glitch counting is enabled by SYNCER_BUS_GLITCH_CNT_EN.
package syncer_pkg;

  localparam int DEF_WIDTH       = 8;
  localparam int DEF_NUM_CH      = 1;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_STABLE_CNT  = 4;
  localparam int DEF_GLITCH_W    = 8;

  // cnt only has to reach STABLE_CNT-1
  function automatic int cnt_width(input int stable_cnt);
    return (stable_cnt <= 2) ? 1 : $clog2(stable_cnt);
  endfunction

  // prime counter runs 0..SYNC_STAGES+1 and then holds
  function automatic int prime_width(input int sync_stages);
    return $clog2(sync_stages + 2);
  endfunction

endpackage

// File: rtl/syncer_bus_filt_ch.sv
// One channel: sync chain, stability qualifier, output register.
// Glitch counter present only with SYNCER_BUS_GLITCH_CNT_EN.
module syncer_bus_filt_ch
  import syncer_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int STABLE_CNT  = DEF_STABLE_CNT
`ifdef SYNCER_BUS_GLITCH_CNT_EN
  ,
  parameter int GLITCH_W    = DEF_GLITCH_W
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             priming,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             ready,
  output logic             upd
`ifdef SYNCER_BUS_GLITCH_CNT_EN
  ,
  input  logic                glitch_clr,
  output logic [GLITCH_W-1:0] glitch_cnt
`endif
);

  localparam int CW = cnt_width(STABLE_CNT);
  localparam logic [CW-1:0] CNT_TOP = CW'(STABLE_CNT - 1);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_d [SYNC_STAGES];
  logic [WIDTH-1:0] cand_q, cand_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             rdy_q, rdy_d;
  logic             upd_q, upd_d;
  logic [WIDTH-1:0] s;
  logic             mism;

  always_comb begin
    sync_d[0] = din;
    for (int k = 1; k < SYNC_STAGES; k++) begin
      sync_d[k] = sync_q[k-1];
    end
    s      = sync_q[SYNC_STAGES-1];
    mism   = priming || (s != cand_q);
    cand_d = cand_q;
    cnt_d  = cnt_q;
    out_d  = out_q;
    rdy_d  = rdy_q;
    upd_d  = 1'b0;
    if (mism) begin
      cand_d = s;
      cnt_d  = '0;
    end else if (cnt_q != CNT_TOP) begin
      cnt_d = cnt_q + 1'b1;
    end else if (!rdy_q || (cand_q != out_q)) begin
      out_d = cand_q;
      rdy_d = 1'b1;
      upd_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '{default: '0};
      cand_q <= '0;
      cnt_q  <= '0;
      out_q  <= '0;
      rdy_q  <= 1'b0;
      upd_q  <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cand_q <= cand_d;
      cnt_q  <= cnt_d;
      out_q  <= out_d;
      rdy_q  <= rdy_d;
      upd_q  <= upd_d;
    end
  end

  assign dout  = out_q;
  assign ready = rdy_q;
  assign upd   = upd_q;

`ifdef SYNCER_BUS_GLITCH_CNT_EN
  localparam logic [GLITCH_W-1:0] GMAX = '1;

  logic [GLITCH_W-1:0] gcnt_q, gcnt_d;
  logic                glitch;

  // a pending value abandoned before it could qualify
  always_comb begin
    glitch = !priming && (s != cand_q) && rdy_q && (cand_q != out_q);
    gcnt_d = gcnt_q;
    if (glitch_clr) begin
      gcnt_d = '0;
    end else if (glitch && (gcnt_q != GMAX)) begin
      gcnt_d = gcnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gcnt_q <= '0;
    end else begin
      gcnt_q <= gcnt_d;
    end
  end

  assign glitch_cnt = gcnt_q;
`endif

endmodule

// File: rtl/syncer_bus_filt.sv
// Multi-channel bus synchronizer with stability qualification.
// Define SYNCER_BUS_GLITCH_CNT_EN for per-channel glitch counters.
module syncer_bus_filt
  import syncer_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int NUM_CH      = DEF_NUM_CH,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int STABLE_CNT  = DEF_STABLE_CNT,
  parameter int GLITCH_W    = DEF_GLITCH_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CH*WIDTH-1:0] busin,
  output logic [NUM_CH*WIDTH-1:0] busout,
  output logic [NUM_CH-1:0]       ready,
  output logic [NUM_CH-1:0]       upd
`ifdef SYNCER_BUS_GLITCH_CNT_EN
  ,
  input  logic                       glitch_clr,
  output logic [NUM_CH*GLITCH_W-1:0] glitch_cnt
`endif
);

  if (SYNC_STAGES < 2 || STABLE_CNT < 1 || GLITCH_W < 1) begin : g_bad_cfg
    $error("syncer_bus_filt: illegal parameter value");
  end

  localparam int PW = prime_width(SYNC_STAGES);
  localparam logic [PW-1:0] PRIME_END = PW'(SYNC_STAGES + 1);

  logic [PW-1:0] prime_q, prime_d;
  logic          priming;

  // keeps stale reset zeros in the chains from ever qualifying
  always_comb begin
    priming = (prime_q != PRIME_END);
    prime_d = priming ? prime_q + 1'b1 : prime_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prime_q <= '0;
    end else begin
      prime_q <= prime_d;
    end
  end

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    syncer_bus_filt_ch #(
      .WIDTH      (WIDTH),
      .SYNC_STAGES(SYNC_STAGES),
      .STABLE_CNT (STABLE_CNT)
`ifdef SYNCER_BUS_GLITCH_CNT_EN
      ,
      .GLITCH_W   (GLITCH_W)
`endif
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .priming   (priming),
      .din       (busin[ch*WIDTH +: WIDTH]),
      .dout      (busout[ch*WIDTH +: WIDTH]),
      .ready     (ready[ch]),
      .upd       (upd[ch])
`ifdef SYNCER_BUS_GLITCH_CNT_EN
      ,
      .glitch_clr(glitch_clr),
      .glitch_cnt(glitch_cnt[ch*GLITCH_W +: GLITCH_W])
`endif
    );
  end

endmodule

// File: tb/tb_syncer_bus_filt.sv
// Bench for syncer_bus_filt: directed scenarios plus random traffic
// against a sequence-level reference model.
module tb_syncer_bus_filt;

  localparam int W    = 8;
  localparam int NA   = 4;
  localparam int GWA  = 8;
  localparam int GWB  = 4;
  localparam int NC   = NA + 1;
  localparam int MAXE = 2048;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic gclr = 1'b0;
  always #5 clk = ~clk;

  logic [NA*W-1:0] bin_a, bout_a;
  logic [NA-1:0]   rdy_a, upd_a;
  logic [W-1:0]    bin_b, bout_b;
  logic [0:0]      rdy_b, upd_b;
`ifdef SYNCER_BUS_GLITCH_CNT_EN
  logic [NA*GWA-1:0] gc_a;
  logic [GWB-1:0]    gc_b;
`endif

  syncer_bus_filt #(
    .WIDTH(W), .NUM_CH(NA), .SYNC_STAGES(2),
    .STABLE_CNT(4), .GLITCH_W(GWA)
  ) u_dut_a (
    .clk(clk), .reset(reset), .busin(bin_a),
    .busout(bout_a), .ready(rdy_a), .upd(upd_a)
`ifdef SYNCER_BUS_GLITCH_CNT_EN
    , .glitch_clr(gclr), .glitch_cnt(gc_a)
`endif
  );

  syncer_bus_filt #(
    .WIDTH(W), .NUM_CH(1), .SYNC_STAGES(3),
    .STABLE_CNT(1), .GLITCH_W(GWB)
  ) u_dut_b (
    .clk(clk), .reset(reset), .busin(bin_b),
    .busout(bout_b), .ready(rdy_b), .upd(upd_b)
`ifdef SYNCER_BUS_GLITCH_CNT_EN
    , .glitch_clr(gclr), .glitch_cnt(gc_b)
`endif
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Model: channels 0..3 are DUT A, channel 4 is DUT B.
  int ss [NC];
  int sc [NC];
  int gmax [NC];
  logic [W-1:0] samp [NC][MAXE+1];
  int nedge;
  logic [W-1:0] m_out [NC];
  logic m_rdy [NC];
  logic m_upd [NC];
  int m_gc [NC];

  // synchronized value seen at edge n: input sampled SS edges earlier
  function automatic logic [W-1:0] s_at(input int c, input int n);
    if (n > ss[c]) return samp[c][n-ss[c]];
    return '0;
  endfunction

  task automatic model_reset();
    nedge = 0;
    for (int c = 0; c < NC; c++) begin
      m_out[c] = '0;
      m_rdy[c] = 1'b0;
      m_upd[c] = 1'b0;
      m_gc[c]  = 0;
    end
  endtask

  task automatic model_edge();
    logic [W-1:0] cur, prev;
    bit qual, gl;
    if (nedge >= MAXE) begin
      $display("FAIL model_overflow got=%0d exp<%0d", nedge, MAXE);
      $fatal(1);
    end
    nedge++;
    for (int c = 0; c < NC; c++) begin
      samp[c][nedge] = (c < NA) ? bin_a[c*W +: W] : bin_b;
      cur  = s_at(c, nedge);
      prev = s_at(c, nedge - 1);
      // qualified: SC+1 equal samples, none of the last SC while priming
      qual = (nedge - sc[c]) >= (ss[c] + 1);
      for (int k = nedge - sc[c]; qual && k < nedge; k++)
        if (s_at(c, k) != cur) qual = 1'b0;
      gl = (nedge > ss[c] + 1) && (cur != prev) && m_rdy[c]
           && (prev != m_out[c]);
      m_upd[c] = 1'b0;
      if (qual && (!m_rdy[c] || cur != m_out[c])) begin
        m_out[c] = cur;
        m_rdy[c] = 1'b1;
        m_upd[c] = 1'b1;
      end
      if (gclr) m_gc[c] = 0;
      else if (gl && m_gc[c] < gmax[c]) m_gc[c]++;
    end
  endtask

  task automatic check_all(input string ph);
    for (int c = 0; c < NA; c++) begin
      chk($sformatf("%s_a%0d_out", ph, c), 32'(bout_a[c*W +: W]), 32'(m_out[c]));
      chk($sformatf("%s_a%0d_rdy", ph, c), 32'(rdy_a[c]), 32'(m_rdy[c]));
      chk($sformatf("%s_a%0d_upd", ph, c), 32'(upd_a[c]), 32'(m_upd[c]));
`ifdef SYNCER_BUS_GLITCH_CNT_EN
      chk($sformatf("%s_a%0d_gc", ph, c), 32'(gc_a[c*GWA +: GWA]), m_gc[c]);
`endif
    end
    chk($sformatf("%s_b_out", ph), 32'(bout_b), 32'(m_out[NA]));
    chk($sformatf("%s_b_rdy", ph), 32'(rdy_b), 32'(m_rdy[NA]));
    chk($sformatf("%s_b_upd", ph), 32'(upd_b), 32'(m_upd[NA]));
`ifdef SYNCER_BUS_GLITCH_CNT_EN
    chk($sformatf("%s_b_gc", ph), 32'(gc_b), m_gc[NA]);
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    if (!reset) model_edge();
    #1;
    check_all("cyc");
  endtask

  // assert reset between edges, hold it over some edges, release between edges
  task automatic do_reset(input int edges);
    #3;
    reset = 1'b1;
    model_reset();
    #1;
    check_all("rst_async");
    repeat (edges) tick();
    #3;
    reset = 1'b0;
  endtask

  task automatic wait_upd(input bit on_b, input int ch, input int budget,
                          output int lat);
    lat = -1;
    for (int i = 1; i <= budget; i++) begin
      tick();
      if (on_b ? upd_b[0] : upd_a[ch]) begin
        lat = i;
        break;
      end
    end
  endtask

  int lat;
  int updc [NC];
  int hold [NC];

  initial begin
    for (int c = 0; c < NA; c++) begin
      ss[c] = 2; sc[c] = 4; gmax[c] = (1 << GWA) - 1;
    end
    ss[NA] = 3; sc[NA] = 1; gmax[NA] = (1 << GWB) - 1;
    bin_a = {8'h11, 8'h11, 8'h11, 8'hA5};
    bin_b = 8'h00;
    model_reset();
    #2;
    reset = 1'b1;
    #1;
    check_all("init");
    repeat (2) tick();
    #3;
    reset = 1'b0;

    // first qualification after reset release
    for (int i = 1; i <= 6; i++) begin
      tick();
      chk("s1_hold_out", 32'(bout_a[7:0]), 32'h00);
      chk("s1_hold_rdy", 32'(rdy_a[0]), 32'h0);
    end
    tick();
    chk("s1_e7_out", 32'(bout_a[7:0]), 32'hA5);
    chk("s1_e7_rdy", 32'(rdy_a[0]), 32'h1);
    chk("s1_e7_upd", 32'(upd_a[0]), 32'h1);
    tick();
    chk("s1_e8_upd", 32'(upd_a[0]), 32'h0);
    repeat (2) tick();

    // held step
    bin_a[7:0] = 8'h3C;
    wait_upd(1'b0, 0, 20, lat);
    chk("s2_latency", lat, 7);
    chk("s2_out", 32'(bout_a[7:0]), 32'h3C);
    tick();
    chk("s2_single_upd", 32'(upd_a[0]), 32'h0);

    // short excursion is filtered
    bin_a[7:0] = 8'hFF;
    repeat (3) tick();
    bin_a[7:0] = 8'h3C;
    updc[0] = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      updc[0] += int'(upd_a[0]);
    end
    chk("s3_no_upd", updc[0], 0);
    chk("s3_out", 32'(bout_a[7:0]), 32'h3C);
`ifdef SYNCER_BUS_GLITCH_CNT_EN
    chk("s3_gcnt", 32'(gc_a[GWA-1:0]), 32'h1);
`endif
    gclr = 1'b1;
    tick();
    gclr = 1'b0;
`ifdef SYNCER_BUS_GLITCH_CNT_EN
    chk("s3_gclr", 32'(gc_a[GWA-1:0]), 32'h0);
`endif

    // one channel of four changes
    bin_a[23:16] = 8'h22;
    for (int c = 0; c < NA; c++) updc[c] = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      for (int c = 0; c < NA; c++) updc[c] += int'(upd_a[c]);
    end
    chk("s4_upd0", updc[0], 0);
    chk("s4_upd1", updc[1], 0);
    chk("s4_upd2", updc[2], 1);
    chk("s4_upd3", updc[3], 0);
    chk("s4_out", bout_a, {8'h11, 8'h22, 8'h11, 8'h3C});

    // reset in the middle of a pending change
    bin_a[7:0] = 8'h5A;
    repeat (5) tick();
    #3;
    reset = 1'b1;
    model_reset();
    #1;
    chk("s5_out", bout_a, 32'h0);
    chk("s5_rdy", 32'(rdy_a), 32'h0);
    chk("s5_upd", 32'(upd_a), 32'h0);
`ifdef SYNCER_BUS_GLITCH_CNT_EN
    chk("s5_gc", gc_a, 32'h0);
`endif
    repeat (2) tick();
    #3;
    reset = 1'b0;
    wait_upd(1'b0, 0, 20, lat);
    chk("s5_requal_lat", lat, 7);
    chk("s5_requal_out", 32'(bout_a[7:0]), 32'h5A);

    // deep chain, single-sample qualification, narrow counter
    repeat (3) tick();
    bin_b = 8'h77;
    wait_upd(1'b1, 0, 20, lat);
    chk("s6_latency", lat, 5);
    updc[NA] = 0;
    for (int i = 0; i < 20; i++) begin
      bin_b = 8'h88;
      tick();
      updc[NA] += int'(upd_b[0]);
      bin_b = 8'h77;
      tick();
      updc[NA] += int'(upd_b[0]);
    end
    repeat (6) tick();
    chk("s6_no_upd", updc[NA], 0);
    chk("s6_out", 32'(bout_b), 32'h77);
`ifdef SYNCER_BUS_GLITCH_CNT_EN
    chk("s6_gc_sat", 32'(gc_b), 32'd15);
`endif

    // random traffic with short and long holds on every channel
    for (int c = 0; c < NC; c++) hold[c] = 0;
    for (int i = 0; i < 400; i++) begin
      for (int c = 0; c < NC; c++) begin
        if (hold[c] == 0) begin
          logic [W-1:0] v;
          case ($urandom_range(0, 3))
            0: v = 8'h00;
            1: v = 8'hFF;
            2: v = 8'h5A;
            default: v = 8'($urandom_range(0, 255));
          endcase
          if (c < NA) bin_a[c*W +: W] = v;
          else bin_b = v;
          hold[c] = $urandom_range(1, 8);
        end
        hold[c]--;
      end
      gclr = ($urandom_range(0, 24) == 0);
      if (i == 200) do_reset(1);
      tick();
    end
    gclr = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
